// File: rtl/rtlola_pkg.sv
// Shared types and constants for the RTLola pacing front end.
// The entry struct documents the default task layout and is the pace_fifo default type.
package rtlola_pkg;

    localparam int NUM_PACES_DEF  = 5;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int TS_WIDTH_DEF   = 32;

    typedef struct packed {
        logic [NUM_PACES_DEF-1:0]  pace_mask;
        logic                      evt;
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [TS_WIDTH_DEF-1:0]   ts;
    } task_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pace_fifo.sv
// Generic first-word-fall-through FIFO over a packed entry type.
// Full and empty are derived from the occupancy counter, not from pointer equality.
module pace_fifo
    import rtlola_pkg::*;
#(
    parameter type T_ENTRY = task_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  T_ENTRY                i_data,
    input  logic                  i_pop,
    output T_ENTRY                o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [clog2(DEPTH):0] o_occupancy
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T_ENTRY             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               w_doPush;
    logic               w_doPop;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_occupancy = r_count;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    assign o_head = o_empty ? T_ENTRY'('0) : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pacing_scheduler.sv
// Timestamps every due cycle (pace tick or input event) and queues one evaluation task per cycle.
// Entries that find the queue full and not draining are dropped and flagged in a sticky overflow bit.
module pacing_scheduler
    import rtlola_pkg::*;
#(
    parameter int NUM_PACES  = NUM_PACES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_PACES-1:0]  tick,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_PACES-1:0]  out_pace_mask,
    output logic                  out_event,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TS_WIDTH-1:0]   out_ts,
    output logic [clog2(DEPTH):0] occupancy,
    output logic                  overflow
);

    typedef struct packed {
        logic [NUM_PACES-1:0]  pace_mask;
        logic                  evt;
        logic [DATA_WIDTH-1:0] data;
        logic [TS_WIDTH-1:0]   ts;
    } entry_t;

    logic [TS_WIDTH-1:0] r_tsCnt;
    logic                r_overflow;
    logic                w_due;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    entry_t              w_entry;
    entry_t              w_head;

    assign w_due  = en & ((|tick) | in_valid);
    assign w_pop  = ~w_empty & out_ready;
    assign w_push = w_due & (~w_full | w_pop);
    assign w_drop = w_due & w_full & ~w_pop;

    always_comb begin
        w_entry           = '0;
        w_entry.pace_mask = tick;
        w_entry.evt       = in_valid;
        w_entry.data      = in_valid ? in_data : '0;
        w_entry.ts        = r_tsCnt;
    end

    // The timestamp counter wraps silently; downstream treats it as modular time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tsCnt    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (en) begin
                r_tsCnt <= r_tsCnt + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    pace_fifo #(
        .T_ENTRY (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (w_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_occupancy (occupancy)
    );

    assign out_valid     = ~w_empty;
    assign out_pace_mask = w_head.pace_mask;
    assign out_event     = w_head.evt;
    assign out_data      = w_head.data;
    assign out_ts        = w_head.ts;
    assign overflow      = r_overflow;

endmodule
